// File: rtl/contador_horas_if.sv
// Hours-stage signal bundle.
// master: drives tick_in, adj_en, adj_inc, mode12 (the minutes stage or a setting UI).
// slave : the hours counter; drives hora, dezena, unidade, pm, day_tick.
interface contador_horas_if;
  logic       tick_in;   // minutes-stage carry strobe
  logic       adj_en;    // adjust mode
  logic       adj_inc;   // manual increment request
  logic       mode12;    // 0 = 24h display, 1 = 12h display
  logic [4:0] hora;      // binary hour count
  logic [1:0] dezena;    // display tens digit (BCD)
  logic [3:0] unidade;   // display units digit (BCD)
  logic       pm;        // hora >= 12
  logic       day_tick;  // one-cycle pulse on natural wrap to 0

  modport master (
    output tick_in, adj_en, adj_inc, mode12,
    input  hora, dezena, unidade, pm, day_tick
  );

  modport slave (
    input  tick_in, adj_en, adj_inc, mode12,
    output hora, dezena, unidade, pm, day_tick
  );
endinterface

// File: rtl/contador_horas.sv
// Hours stage of the clock chain.
// Counts 0..MAX_HOUR-1 on rising edges of the minutes carry (or of adj_inc
// while in adjust mode), and presents BCD display digits in 24h/12h format,
// a PM flag and a one-cycle day-carry pulse.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-low
//   bus   - contador_horas_if.slave (strobes, mode inputs, hour outputs)
module contador_horas #(
  parameter int unsigned MAX_HOUR = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  contador_horas_if.slave       bus
);

  logic       r_tick_q;
  logic       r_inc_q;
  logic [4:0] r_hora;
  logic       r_day_tick;

  logic       w_tick_ev;
  logic       w_inc_ev;
  logic       w_step;
  logic       w_last;
  logic [4:0] w_hora_next;
  logic [4:0] w_disp;
  logic [1:0] w_dez;
  logic [4:0] w_uni;

  assign w_tick_ev   = bus.tick_in & ~r_tick_q;
  assign w_inc_ev    = bus.adj_inc & ~r_inc_q;
  // adj_en picks exactly one event source, so at most one increment per cycle
  assign w_step      = bus.adj_en ? w_inc_ev : w_tick_ev;
  assign w_last      = (r_hora == 5'(MAX_HOUR - 1));
  assign w_hora_next = w_last ? '0 : r_hora + 5'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hora     <= '0;
      r_day_tick <= 1'b0;
      r_tick_q   <= 1'b0;
      r_inc_q    <= 1'b0;
    end else begin
      // edge registers track their inputs in both modes, so leaving adjust
      // with a strobe already high does not fabricate an event
      r_tick_q   <= bus.tick_in;
      r_inc_q    <= bus.adj_inc;
      r_day_tick <= ~bus.adj_en & w_tick_ev & w_last;
      if (w_step) begin
        r_hora <= w_hora_next;
      end
    end
  end

  always_comb begin
    w_disp = r_hora;
    if (bus.mode12) begin
      if (r_hora == 5'd0) begin
        w_disp = 5'd12;
      end else if (r_hora > 5'd12) begin
        w_disp = r_hora - 5'd12;
      end
    end
  end

  // divide-by-10 by comparison; w_disp never exceeds 31
  always_comb begin
    w_dez = 2'd0;
    w_uni = w_disp;
    if (w_disp >= 5'd30) begin
      w_dez = 2'd3;
      w_uni = w_disp - 5'd30;
    end else if (w_disp >= 5'd20) begin
      w_dez = 2'd2;
      w_uni = w_disp - 5'd20;
    end else if (w_disp >= 5'd10) begin
      w_dez = 2'd1;
      w_uni = w_disp - 5'd10;
    end
  end

  assign bus.hora     = r_hora;
  assign bus.day_tick = r_day_tick;
  assign bus.dezena   = w_dez;
  assign bus.unidade  = w_uni[3:0];
  assign bus.pm       = (r_hora >= 5'd12);

endmodule

// File: tb/tb_contador_horas.sv
module tb_contador_horas;

  logic clk;
  logic reset;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   cur;

  contador_horas_if bus ();

  contador_horas #(.MAX_HOUR(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         cyc;
    logic [4:0] h;
    logic [1:0] dz;
    logic [3:0] un;
    logic       pm;
    logic       dt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  // Monitor: the DUT presents a fresh output state every cycle; entries
  // tagged for the current cycle are popped and compared mid-cycle.
  always @(negedge clk) begin
    exp_t  e;
    string n;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors = vectors + 1;
      if (bus.hora !== e.h || bus.dezena !== e.dz || bus.unidade !== e.un ||
          bus.pm !== e.pm || bus.day_tick !== e.dt) begin
        miscompares = miscompares + 1;
        $display("FAIL %s: got hora=%0d dez=%0d uni=%0d pm=%0b dt=%0b, need hora=%0d dez=%0d uni=%0d pm=%0b dt=%0b",
                 n, bus.hora, bus.dezena, bus.unidade, bus.pm, bus.day_tick,
                 e.h, e.dz, e.un, e.pm, e.dt);
      end
    end
  end

  task automatic expect_now(input string n, input int h, input int dz, input int un,
                            input bit p, input bit dt);
    exp_t e;
    e.cyc = cyc;
    e.h   = 5'(h);
    e.dz  = 2'(dz);
    e.un  = 4'(un);
    e.pm  = p;
    e.dt  = dt;
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one-cycle tick pulse; returns in the cycle where the new hour is visible
  task automatic tick();
    bus.tick_in = 1'b1;
    step();
    bus.tick_in = 1'b0;
    cur = (cur + 1) % 24;
  endtask

  task automatic goto_hour(input int h);
    while (cur != h) begin
      step();
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need completion");
    $fatal(1);
  end

  initial begin
    cyc = 0; vectors = 0; miscompares = 0; cur = 0;
    reset = 1'b0;
    bus.tick_in = 1'b0; bus.adj_en = 1'b0; bus.adj_inc = 1'b0; bus.mode12 = 1'b0;
    step(); step();
    expect_now("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    step();
    expect_now("post_reset", 0, 0, 0, 0, 0);

    // full day in 24h format
    for (int i = 1; i <= 23; i++) begin
      repeat (4) step();
      tick();
      expect_now("count", i, i / 10, i % 10, i >= 12, 0);
    end
    repeat (4) step();
    tick();
    expect_now("wrap", 0, 0, 0, 0, 1);
    step();
    expect_now("wrap_pulse_end", 0, 0, 0, 0, 0);

    // held strobe counts once
    goto_hour(5);
    step();
    expect_now("at5", 5, 0, 5, 0, 0);
    bus.tick_in = 1'b1;
    step();
    expect_now("held_first", 6, 0, 6, 0, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      expect_now("held", 6, 0, 6, 0, 0);
    end
    bus.tick_in = 1'b0;
    step();
    expect_now("held_release", 6, 0, 6, 0, 0);
    cur = 6;

    // 12h display sweep
    bus.mode12 = 1'b1;
    goto_hour(12);
    expect_now("m12_h12", 12, 1, 2, 1, 0);
    goto_hour(13);
    expect_now("m12_h13", 13, 0, 1, 1, 0);
    goto_hour(23);
    expect_now("m12_h23", 23, 1, 1, 1, 0);
    goto_hour(0);
    expect_now("m12_h0", 0, 1, 2, 0, 1);
    goto_hour(9);
    expect_now("m12_h9", 9, 0, 9, 0, 0);
    bus.mode12 = 1'b0;
    #1;
    expect_now("m24_h9", 9, 0, 9, 0, 0);

    // adjust mode across the wrap, with concurrent ticks
    goto_hour(23);
    step();
    bus.adj_en = 1'b1;
    step();
    expect_now("adj_enter", 23, 2, 3, 1, 0);
    for (int k = 0; k < 3; k++) begin
      bus.adj_inc = 1'b1;
      bus.tick_in = 1'b1;
      step();
      expect_now("adj_inc", k, 0, k, 0, 0);
      bus.adj_inc = 1'b0;
      bus.tick_in = 1'b0;
      step();
      expect_now("adj_hold", k, 0, k, 0, 0);
    end
    bus.adj_en = 1'b0;
    step();
    expect_now("adj_exit", 2, 0, 2, 0, 0);
    cur = 2;
    tick();
    expect_now("after_adj_tick", 3, 0, 3, 0, 0);
    step();
    bus.adj_inc = 1'b1;
    step();
    expect_now("inc_ignored", 3, 0, 3, 0, 0);
    bus.adj_inc = 1'b0;

    // reset during a tick pulse at 23
    goto_hour(23);
    step();
    bus.tick_in = 1'b1;
    reset = 1'b0;
    step();
    expect_now("reset_mid_tick", 0, 0, 0, 0, 0);
    reset = 1'b1;
    bus.tick_in = 1'b0;
    cur = 0;
    step();
    expect_now("after_reset", 0, 0, 0, 0, 0);
    tick();
    expect_now("after_reset_tick", 1, 0, 1, 0, 0);

    // drain scoreboard within a bounded window
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) step();
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL drain: got %0d pending, need 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
